// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane-banked data memory.
package dmem_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_t;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic logic [LANES-1:0] lane_mask(size_t size, logic [1:0] off);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(logic [31:0] word, logic [1:0] off,
                                              size_t size, logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_extend = {{24{sgn & b[7]}}, b};
      SZ_HALF: load_extend = {{16{sgn & h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte lane of storage: DEPTH x 8 single-port RAM, registered read.
// A same-edge write and read returns the old contents (read-before-write).
module dmem_bank #(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_lanes.sv
// Banked data memory with valid/ready requests, one-cycle registered responses,
// byte/half/word steering, load extension, error flagging and post-reset clear.
module dmem_lanes
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 512,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int ADDR_BITS = $clog2(DEPTH);

  state_t                 state;
  logic [ADDR_BITS-1:0]   clr_cnt;
  size_t                  req_sz;
  logic [1:0]             off;
  logic [ADDR_BITS-1:0]   widx;
  logic                   out_of_range;
  logic                   err;
  logic                   accept;
  logic                   clearing;
  logic [LANES-1:0]       wmask;
  logic [31:0]            wrep;
  logic [31:0]            rd_word;

  logic                   vld_q;
  logic                   err_q;
  logic                   ld_q;
  logic [1:0]             off_q;
  size_t                  size_q;
  logic                   sgn_q;

  assign req_sz       = size_t'(req_size);
  assign off          = req_addr[1:0];
  assign widx         = req_addr[ADDR_BITS+1:2];
  assign out_of_range = |(req_addr >> (ADDR_BITS + 2));
  assign err          = (req_sz == SZ_RSVD)
                      | ((req_sz == SZ_HALF) & off[0])
                      | ((req_sz == SZ_WORD) & (|off))
                      | out_of_range;

  assign req_ready = (state == READY) & ~reset;
  assign accept    = req_valid & req_ready;
  assign clearing  = (state == CLEAR) & ~reset;

  // Replicate store data so every enabled lane just takes its own slice.
  assign wmask = lane_mask(req_sz, off);
  always_comb begin
    wrep = req_wdata;
    if (req_sz == SZ_BYTE)      wrep = {4{req_wdata[7:0]}};
    else if (req_sz == SZ_HALF) wrep = {2{req_wdata[15:0]}};
  end

  for (genvar i = 0; i < LANES; i++) begin : g_bank
    dmem_bank #(.DEPTH(DEPTH)) u_bank (
      .clk   (clk),
      .we    (clearing | (accept & req_we & ~err & wmask[i])),
      .addr  ((state == CLEAR) ? clr_cnt : widx),
      .wdata (clearing ? 8'h00 : wrep[8*i +: 8]),
      .rdata (rd_word[8*i +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT_CLEAR ? CLEAR : READY;
      clr_cnt <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
      off_q   <= 2'd0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_BITS'(DEPTH - 1)) state <= READY;
        end
        default: state <= READY;
      endcase
      vld_q  <= accept;
      err_q  <= accept & err;
      ld_q   <= accept & ~req_we & ~err;
      off_q  <= off;
      size_q <= req_sz;
      sgn_q  <= req_signed;
    end
  end

  assign rsp_valid = vld_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = ld_q ? load_extend(rd_word, off_q, size_q, sgn_q) : 32'h0;

endmodule

// File: tb/tb_dmem_lanes.sv
// Directed plus randomized checks of dmem_lanes against a byte-array reference model.
module tb_dmem_lanes;

  localparam int DEPTH  = 16;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_lanes #(.DEPTH(DEPTH), .INIT_CLEAR(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  byte unsigned mem [NBYTES];
  bit          exp_vld;
  bit          exp_err;
  bit [31:0]   exp_data;
  bit          exp_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input bit [1:0] sz, input bit [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
           (sz == 2'd2 && a % 4 != 0) || (a >= NBYTES);
  endfunction

  function automatic bit [31:0] model_load(input bit [1:0] sz, input bit sgn, input bit [31:0] a);
    int nb;
    longint v;
    nb = 1 << sz;
    v = 0;
    for (int k = 0; k < nb; k++) v += longint'(mem[a + k]) << (8 * k);
    if (sgn && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic model_store(input bit [1:0] sz, input bit [31:0] a, input bit [31:0] wd);
    for (int k = 0; k < (1 << sz); k++) mem[a + k] = wd[8 * k +: 8];
  endtask

  // Called at a falling edge: check the response to the previous step, then drive the next request.
  task automatic step(input bit v, input bit we, input bit [1:0] sz, input bit sgn,
                      input bit [31:0] a, input bit [31:0] wd, input string tag);
    chk({tag, " rsp_valid"}, rsp_valid, exp_vld);
    chk({tag, " rsp_err"}, rsp_err, exp_err);
    chk({tag, " rsp_rdata"}, rsp_rdata, exp_data);
    chk({tag, " req_ready"}, req_ready, exp_rdy);
    req_valid  = v;
    req_we     = we;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = a;
    req_wdata  = wd;
    if (v && exp_rdy) begin
      exp_vld  = 1'b1;
      exp_err  = model_err(sz, a);
      exp_data = (exp_err || we) ? 32'h0 : model_load(sz, sgn, a);
      if (!exp_err && we) model_store(sz, a, wd);
    end else begin
      exp_vld  = 1'b0;
      exp_err  = 1'b0;
      exp_data = 32'h0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    reset     = 1'b1;
    req_valid = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("reset req_ready", req_ready, 0);
      chk("reset rsp_valid", rsp_valid, 0);
      chk("reset rsp_rdata", rsp_rdata, 0);
      chk("reset rsp_err", rsp_err, 0);
    end
    reset = 1'b0;
    #1 chk("clear ready cycle0", req_ready, 0);
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge clk);
      chk($sformatf("clear ready cycle%0d", k), req_ready, (k == DEPTH) ? 1 : 0);
    end
    for (int k = 0; k < NBYTES; k++) mem[k] = 8'h00;
    exp_vld  = 1'b0;
    exp_err  = 1'b0;
    exp_data = 32'h0;
    exp_rdy  = 1'b1;
  endtask

  initial begin
    exp_rdy = 1'b0;
    @(negedge clk);
    do_reset(3);

    for (int w = 0; w < DEPTH; w++) step(1, 0, 2'd2, 0, 32'(w * 4), 32'h0, "cleared word");

    step(1, 1, 2'd2, 0, 32'h8, 32'h8899AABB, "word store");
    step(1, 1, 2'd0, 0, 32'h9, 32'h00000011, "byte store");
    step(1, 0, 2'd2, 0, 32'h8, 32'h0, "merged word load");

    step(1, 1, 2'd2, 0, 32'h8, 32'h80FF7F01, "ext store");
    step(1, 0, 2'd0, 1, 32'hB, 32'h0, "lb signed");
    step(1, 0, 2'd0, 0, 32'hB, 32'h0, "lb unsigned");
    step(1, 0, 2'd1, 1, 32'h8, 32'h0, "lh signed lo");
    step(1, 0, 2'd1, 1, 32'hA, 32'h0, "lh signed hi");
    step(1, 0, 2'd1, 0, 32'hA, 32'h0, "lh unsigned hi");

    step(1, 0, 2'd1, 0, 32'h3, 32'h0, "misaligned half");
    step(1, 0, 2'd2, 0, 32'h6, 32'h0, "misaligned word");
    step(1, 1, 2'd3, 0, 32'h8, 32'hFFFFFFFF, "reserved size store");
    step(1, 0, 2'd2, 0, 32'h8, 32'h0, "after reserved");
    step(1, 1, 2'd2, 0, 32'h40, 32'h12345678, "out of range store");
    step(1, 0, 2'd2, 0, 32'h0, 32'h0, "word0 after oor");

    step(1, 1, 2'd2, 0, 32'h4, 32'hDEADBEEF, "b2b store");
    step(1, 0, 2'd2, 0, 32'h4, 32'h0, "b2b load");
    step(0, 0, 2'd0, 0, 32'h0, 32'h0, "idle");

    for (int n = 0; n < 400; n++) begin
      bit [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, NBYTES + 7));
      step($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), 1'($urandom),
           a, $urandom, "random");
    end
    step(0, 0, 2'd0, 0, 32'h0, 32'h0, "flush");

    step(1, 1, 2'd2, 0, 32'h0, 32'hCAFEF00D, "pre-reset store");
    step(1, 0, 2'd2, 0, 32'h0, 32'h0, "pre-reset load");
    chk("pending rsp_valid", rsp_valid, 1);
    chk("pending rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    do_reset(1);
    for (int w = 0; w < 4; w++) step(1, 0, 2'd2, 0, 32'(w * 4), 32'h0, "recleared word");
    step(0, 0, 2'd0, 0, 32'h0, 32'h0, "final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
